uart_to_shk: RTL and testbench

Receive-side companion to the shake-to-UART transmitter: deserialises 8N1 UART bytes from the host line, pairs them into {address, data} frames and replays each frame as a shake-bus write transaction (master side). It sits between the board UART RX pin and any shake-bus slave (register bank, the shake-to-UART bridge loopback), closing the host→fabric command path.

---
 rtl/uart_shk_pkg.sv | 35 +++
 rtl/uart_rx_byte.sv | 140 ++++++++++++++
 rtl/uart_to_shk.sv | 135 +++++++++++++
 tb/tb_uart_to_shk.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_shk_pkg.sv
// Shared definitions for the UART <-> shake-bus bridges: baud arithmetic,
// FSM state encodings and error vector bit positions.
package uart_shk_pkg;

    localparam int ERR_FRAME   = 0;
    localparam int ERR_PARITY  = 1;
    localparam int ERR_OVERRUN = 2;
    localparam int ERR_TIMEOUT = 3;

    typedef enum logic [2:0] {
        F_ADDR,
        F_DATA,
        F_WAIT,
        F_VALID,
        F_SYNC
    } frame_state_t;

    typedef enum logic [2:0] {
        R_IDLE,
        R_START,
        R_DATA,
        R_PARITY,
        R_STOP,
        R_WAIT_HIGH
    } rx_state_t;

    function automatic int baud_numb(input int sys_fre, input int baud_rate);
        return sys_fre / baud_rate;
    endfunction

    function automatic int cnt_width(input int numb);
        return $clog2(numb + 1);
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// UART byte receiver: 2-flop synchroniser, mid-bit sampling, byte/error strobes.
// UART_TO_SHK_PARITY_EN selects 8E1 framing; otherwise 8N1.
module uart_rx_byte
    import uart_shk_pkg::*;
#(
    parameter int NB_BAUD_NUMB = 868
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic       busy,
    output logic       byte_ok,
    output logic [7:0] byte_data,
    output logic       err_frame,
    output logic       err_parity
);

    localparam int CNT_W = cnt_width(NB_BAUD_NUMB);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NB_BAUD_NUMB - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(NB_BAUD_NUMB / 2 - 1);

    logic [1:0]       sync_q;
    logic             rx_d;
    logic             rx_s;
    logic             fall;
    logic             tc;
    logic             stop_hit;
    logic             par_ok;
    rx_state_t        state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [2:0]       bit_idx, bit_idx_nxt;
    logic [7:0]       shreg, shreg_nxt;

    assign rx_s = sync_q[1];
    assign fall = rx_d & ~rx_s;
    assign tc   = (cnt == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q  <= 2'b11;
            rx_d    <= 1'b1;
            state   <= R_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            sync_q  <= {sync_q[0], rx};
            rx_d    <= rx_s;
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bit_idx <= bit_idx_nxt;
            shreg   <= shreg_nxt;
        end
    end

`ifdef UART_TO_SHK_PARITY_EN
    logic par_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            par_q <= 1'b0;
        end else if (state == R_PARITY && tc) begin
            par_q <= rx_s;
        end
    end

    // Even parity: the parity bit must equal the XOR of the data bits.
    assign par_ok = (par_q == ^shreg);
`else
    assign par_ok = 1'b1;
`endif

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt - 1'b1;
        bit_idx_nxt = bit_idx;
        shreg_nxt   = shreg;
        case (state)
            R_IDLE: begin
                if (fall) begin
                    state_nxt = R_START;
                    cnt_nxt   = CNT_HALF;
                end
            end
            R_START: begin
                if (tc) begin
                    if (rx_s) begin
                        state_nxt = R_IDLE;
                    end else begin
                        state_nxt   = R_DATA;
                        cnt_nxt     = CNT_FULL;
                        bit_idx_nxt = '0;
                    end
                end
            end
            R_DATA: begin
                if (tc) begin
                    shreg_nxt   = {rx_s, shreg[7:1]};
                    cnt_nxt     = CNT_FULL;
                    bit_idx_nxt = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
`ifdef UART_TO_SHK_PARITY_EN
                        state_nxt = R_PARITY;
`else
                        state_nxt = R_STOP;
`endif
                    end
                end
            end
`ifdef UART_TO_SHK_PARITY_EN
            R_PARITY: begin
                if (tc) begin
                    state_nxt = R_STOP;
                    cnt_nxt   = CNT_FULL;
                end
            end
`endif
            R_STOP: begin
                // A low stop bit means the line may still be low; re-arm only once it idles.
                if (tc) begin
                    state_nxt = rx_s ? R_IDLE : R_WAIT_HIGH;
                end
            end
            R_WAIT_HIGH: begin
                if (rx_s) begin
                    state_nxt = R_IDLE;
                end
            end
            default: state_nxt = R_IDLE;
        endcase
    end

    assign stop_hit   = (state == R_STOP) && tc;
    assign byte_ok    = stop_hit & rx_s & par_ok;
    assign err_frame  = stop_hit & ~rx_s;
    assign err_parity = stop_hit & rx_s & ~par_ok;
    assign byte_data  = shreg;
    assign busy       = (state != R_IDLE) || fall;

endmodule

// File: rtl/uart_to_shk.sv
// UART RX to shake-bus write master: pairs {address, data} bytes into writes.
// UART_TO_SHK_PARITY_EN enables 8E1 framing and the parity error bit.
//
// state   | meaning
// F_ADDR  | waiting for the address byte
// F_DATA  | address held, waiting for data byte, inter-byte timeout running
// F_WAIT  | frame complete, waiting for m_shk_wr_ready
// F_VALID | m_shk_wr_valid pulse
// F_SYNC  | m_shk_wr_msync pulse
module uart_to_shk
    import uart_shk_pkg::*;
#(
    parameter int NB_BAUD_RATE   = 115200,
    parameter int NB_SYS_FRE     = 100_000_000,
    parameter int NB_TIMEOUT_BIT = 20,
    parameter int WD_SHK_DATA    = 8,
    parameter int WD_SHK_ADDR    = 8,
    parameter int WD_ERR_INFO    = 4
) (
    input  logic                   i_sys_clk,
    input  logic                   i_sys_reset,
    input  logic                   s_port_uart_rx,
    output logic                   m_shk_wr_valid,
    output logic                   m_shk_wr_msync,
    output logic [WD_SHK_DATA-1:0] m_shk_wr_mdata,
    output logic [WD_SHK_ADDR-1:0] m_shk_wr_maddr,
    input  logic                   m_shk_wr_ready,
    input  logic                   i_err_clr,
    output logic [WD_ERR_INFO-1:0] m_err_uart_info1
);

    localparam int NB_BAUD_NUMB = baud_numb(NB_SYS_FRE, NB_BAUD_RATE);
    localparam int TMO_NUMB     = NB_TIMEOUT_BIT * NB_BAUD_NUMB;
    localparam int TMO_W        = cnt_width(TMO_NUMB);
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TMO_NUMB - 1);

    logic                   rx_busy;
    logic                   rx_byte_ok;
    logic [7:0]             rx_byte_data;
    logic                   rx_err_frame;
    logic                   rx_err_parity;
    frame_state_t           state, state_nxt;
    logic [TMO_W-1:0]       tmr;
    logic                   timeout;
    logic [WD_SHK_ADDR-1:0] addr_pend;
    logic [WD_ERR_INFO-1:0] err_q;
    logic [WD_ERR_INFO-1:0] err_set;
    logic                   busy_frame;

    uart_rx_byte #(
        .NB_BAUD_NUMB (NB_BAUD_NUMB)
    ) u_rx (
        .clk        (i_sys_clk),
        .reset      (i_sys_reset),
        .rx         (s_port_uart_rx),
        .busy       (rx_busy),
        .byte_ok    (rx_byte_ok),
        .byte_data  (rx_byte_data),
        .err_frame  (rx_err_frame),
        .err_parity (rx_err_parity)
    );

    // Timer restarts whenever a byte is in flight, so it only measures idle line time.
    always_ff @(posedge i_sys_clk) begin
        if (i_sys_reset) begin
            tmr <= TMO_LOAD;
        end else if (state != F_DATA || rx_busy) begin
            tmr <= TMO_LOAD;
        end else if (tmr != '0) begin
            tmr <= tmr - 1'b1;
        end
    end

    assign timeout    = (state == F_DATA) && !rx_busy && (tmr == '0);
    assign busy_frame = (state == F_WAIT) || (state == F_VALID) || (state == F_SYNC);

    always_ff @(posedge i_sys_clk) begin
        if (i_sys_reset) begin
            state          <= F_ADDR;
            addr_pend      <= '0;
            m_shk_wr_maddr <= '0;
            m_shk_wr_mdata <= '0;
            err_q          <= '0;
        end else begin
            state <= state_nxt;
            if (state == F_ADDR && rx_byte_ok) begin
                addr_pend <= WD_SHK_ADDR'(rx_byte_data);
            end
            if (state == F_DATA && rx_byte_ok) begin
                m_shk_wr_maddr <= addr_pend;
                m_shk_wr_mdata <= WD_SHK_DATA'(rx_byte_data);
            end
            err_q <= (err_q & ~{WD_ERR_INFO{i_err_clr}}) | err_set;
        end
    end

    always_comb begin
        err_set              = '0;
        err_set[ERR_FRAME]   = rx_err_frame;
        err_set[ERR_PARITY]  = rx_err_parity;
        err_set[ERR_OVERRUN] = rx_byte_ok && busy_frame;
        err_set[ERR_TIMEOUT] = timeout;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            F_ADDR: begin
                if (rx_byte_ok) begin
                    state_nxt = F_DATA;
                end
            end
            F_DATA: begin
                if (rx_byte_ok) begin
                    state_nxt = m_shk_wr_ready ? F_VALID : F_WAIT;
                end else if (rx_err_frame || rx_err_parity || timeout) begin
                    state_nxt = F_ADDR;
                end
            end
            F_WAIT: begin
                if (m_shk_wr_ready) begin
                    state_nxt = F_VALID;
                end
            end
            F_VALID: state_nxt = F_SYNC;
            F_SYNC:  state_nxt = F_ADDR;
            default: state_nxt = F_ADDR;
        endcase
    end

    assign m_shk_wr_valid   = (state == F_VALID);
    assign m_shk_wr_msync   = (state == F_SYNC);
    assign m_err_uart_info1 = err_q;

endmodule

// File: tb/tb_uart_to_shk.sv
// Directed self-checking bench for uart_to_shk at 16 clocks per bit.
module tb_uart_to_shk;

    localparam int BIT = 16;

    logic       clk;
    logic       rst;
    logic       rx;
    logic       valid;
    logic       msync;
    logic [7:0] mdata;
    logic [7:0] maddr;
    logic       ready;
    logic       clr;
    logic [3:0] err;

    int tests;
    int fails;
    int wr_count;
    int sync_count;
    int bad;
    logic prev_valid;
    logic [7:0] last_addr;
    logic [7:0] last_data;

`ifdef UART_TO_SHK_PARITY_EN
    logic par_force_en;
    logic par_force_val;
`endif

    uart_to_shk #(
        .NB_BAUD_RATE   (100_000),
        .NB_SYS_FRE     (1_600_000),
        .NB_TIMEOUT_BIT (20),
        .WD_SHK_DATA    (8),
        .WD_SHK_ADDR    (8),
        .WD_ERR_INFO    (4)
    ) dut (
        .i_sys_clk        (clk),
        .i_sys_reset      (rst),
        .s_port_uart_rx   (rx),
        .m_shk_wr_valid   (valid),
        .m_shk_wr_msync   (msync),
        .m_shk_wr_mdata   (mdata),
        .m_shk_wr_maddr   (maddr),
        .m_shk_wr_ready   (ready),
        .i_err_clr        (clr),
        .m_err_uart_info1 (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        prev_valid <= valid;
        if (valid) begin
            wr_count  <= wr_count + 1;
            last_addr <= maddr;
            last_data <= mdata;
        end
        if (msync) sync_count <= sync_count + 1;
        if ((valid && prev_valid) || (msync && !prev_valid) || (valid && msync))
            bad <= bad + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_v);
        rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BIT) @(negedge clk);
        end
`ifdef UART_TO_SHK_PARITY_EN
        rx = par_force_en ? par_force_val : ^b;
        repeat (BIT) @(negedge clk);
`endif
        rx = stop_v;
        repeat (BIT) @(negedge clk);
        rx = 1'b1;
        repeat (2 * BIT) @(negedge clk);
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        tests = 0; fails = 0;
        wr_count = 0; sync_count = 0; bad = 0;
        prev_valid = 1'b0; last_addr = '0; last_data = '0;
`ifdef UART_TO_SHK_PARITY_EN
        par_force_en = 1'b0; par_force_val = 1'b0;
`endif
        rst = 1'b1; rx = 1'b1; ready = 1'b1; clr = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", valid, 0);
        chk("rst_msync", msync, 0);
        chk("rst_maddr", maddr, 0);
        chk("rst_mdata", mdata, 0);
        chk("rst_err", err, 0);

        // Basic frame, ready high
        send_byte(8'h5A, 1'b1);
        send_byte(8'hC3, 1'b1);
        repeat (5) @(negedge clk);
        chk("t1_wr_count", wr_count, 1);
        chk("t1_sync_count", sync_count, 1);
        chk("t1_addr", last_addr, 8'h5A);
        chk("t1_data", last_data, 8'hC3);
        chk("t1_maddr_held", maddr, 8'h5A);
        chk("t1_err", err, 0);

        // Ready held low for 100 cycles
        ready = 1'b0;
        send_byte(8'hAB, 1'b1);
        send_byte(8'hCD, 1'b1);
        repeat (100) @(negedge clk);
        chk("t2_no_valid", wr_count, 1);
        chk("t2_no_msync", sync_count, 1);
        ready = 1'b1;
        @(negedge clk);
        chk("t2_valid_hi", valid, 1);
        chk("t2_msync_lo", msync, 0);
        @(negedge clk);
        chk("t2_valid_lo", valid, 0);
        chk("t2_msync_hi", msync, 1);
        @(negedge clk);
        chk("t2_maddr", maddr, 8'hAB);
        chk("t2_mdata", mdata, 8'hCD);

        // Inter-byte timeout
        send_byte(8'h10, 1'b1);
        repeat (25 * BIT) @(negedge clk);
        chk("t3_timeout_err", err, 4'b1000);
        send_byte(8'h20, 1'b1);
        send_byte(8'h30, 1'b1);
        repeat (5) @(negedge clk);
        chk("t3_wr_count", wr_count, 3);
        chk("t3_addr", last_addr, 8'h20);
        chk("t3_data", last_data, 8'h30);
        pulse_clr();
        chk("t3_clr", err, 0);

        // Framing error
        send_byte(8'h11, 1'b0);
        chk("t4_frame_err", err, 4'b0001);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        repeat (5) @(negedge clk);
        chk("t4_wr_count", wr_count, 4);
        chk("t4_addr", last_addr, 8'h22);
        chk("t4_data", last_data, 8'h33);
        pulse_clr();
        chk("t4_clr", err, 0);

        // Overrun while waiting for ready
        ready = 1'b0;
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h03, 1'b1);
        chk("t5_overrun_err", err, 4'b0100);
        chk("t5_no_write", wr_count, 4);
        ready = 1'b1;
        repeat (5) @(negedge clk);
        chk("t5_wr_count", wr_count, 5);
        chk("t5_addr", last_addr, 8'h01);
        chk("t5_data", last_data, 8'h02);
        pulse_clr();
        send_byte(8'h04, 1'b1);
        send_byte(8'h05, 1'b1);
        repeat (5) @(negedge clk);
        chk("t5_next_addr", last_addr, 8'h04);
        chk("t5_next_data", last_data, 8'h05);

        // False start glitch is ignored without error
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (3 * BIT) @(negedge clk);
        send_byte(8'hA1, 1'b1);
        send_byte(8'hB2, 1'b1);
        repeat (5) @(negedge clk);
        chk("t6_wr_count", wr_count, 7);
        chk("t6_addr", last_addr, 8'hA1);
        chk("t6_data", last_data, 8'hB2);
        chk("t6_err", err, 0);

        // Reset in the middle of a frame
        send_byte(8'h55, 1'b1);
        rx = 1'b0;
        repeat (3 * BIT) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        rst = 1'b0;
        @(negedge clk);
        chk("t7_maddr", maddr, 0);
        chk("t7_mdata", mdata, 0);
        repeat (4 * BIT) @(negedge clk);
        chk("t7_no_write", wr_count, 7);
        send_byte(8'h66, 1'b1);
        send_byte(8'h77, 1'b1);
        repeat (5) @(negedge clk);
        chk("t7_wr_count", wr_count, 8);
        chk("t7_addr", last_addr, 8'h66);
        chk("t7_data", last_data, 8'h77);
        chk("t7_err", err, 0);

`ifdef UART_TO_SHK_PARITY_EN
        par_force_en = 1'b1;
        par_force_val = 1'b0;
        send_byte(8'h07, 1'b1);
        par_force_en = 1'b0;
        chk("t8_parity_err", err, 4'b0010);
        chk("t8_no_write", wr_count, 8);
        send_byte(8'h07, 1'b1);
        send_byte(8'h08, 1'b1);
        repeat (5) @(negedge clk);
        chk("t8_wr_count", wr_count, 9);
        chk("t8_addr", last_addr, 8'h07);
        chk("t8_data", last_data, 8'h08);
`endif

        chk("pulse_shape", bad, 0);
        chk("msync_per_valid", sync_count, wr_count);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
